// File: rtl/amy_kpd_pkg.sv
// Shared keypad geometry, scan FSM state type and row-drive helper.
package amy_kpd_pkg;

    localparam int unsigned KPD_ROWS  = 5;
    localparam int unsigned KPD_COLS  = 5;
    localparam int unsigned KPD_KEYS  = 25;
    localparam int unsigned KPD_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_FRAME
    } kpd_state_e;

    // One-hot-low row drive pattern for the given row index.
    function automatic logic [KPD_ROWS-1:0] row_drive(input logic [2:0] idx);
        logic [KPD_ROWS-1:0] r;
        r      = '1;
        r[idx] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/kpd_prio_enc.sv
// Lowest-set-bit priority encoder over the 25-key map.
module kpd_prio_enc
    import amy_kpd_pkg::*;
(
    input  logic [KPD_KEYS-1:0]  mask,
    output logic                 found,
    output logic [KPD_IDX_W-1:0] idx
);

    // Scan upward so the first set bit found is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < KPD_KEYS; i++) begin
            if (mask[i] && !found) begin
                found = 1'b1;
                idx   = KPD_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 5x5 matrix keypad scanner: row strobing, column sampling, frame debounce
// and a single-entry press/release event slot with ready/valid handshake.
module keypad_scan_ctrl
    import amy_kpd_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEB_FRAMES = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 scan_en,
    output logic [KPD_ROWS-1:0]  row,
    input  logic [KPD_COLS-1:0]  col,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic [KPD_IDX_W-1:0] key_code,
    output logic                 key_rel,
    output logic [KPD_KEYS-1:0]  key_state
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 2);
    localparam logic [3:0]  DEB_TH   = 4'(DEB_FRAMES);

    kpd_state_e            state;
    logic [KPD_COLS-1:0]   col_meta, col_sync;
    logic [2:0]            row_idx;
    logic [15:0]           div_cnt;
    logic [KPD_KEYS-1:0]   snapshot, prev_snap;
    logic [3:0]            deb_cnt, deb_next;
    logic [KPD_KEYS-1:0]   pend_press, pend_rel;
    logic [KPD_KEYS-1:0]   set_press, set_rel, clr_press, clr_rel;
    logic                  accept, slot_load;
    logic                  press_found, rel_found;
    logic [KPD_IDX_W-1:0]  press_idx, rel_idx;

    kpd_prio_enc u_press_enc (
        .mask  (pend_press),
        .found (press_found),
        .idx   (press_idx)
    );

    kpd_prio_enc u_rel_enc (
        .mask  (pend_rel),
        .found (rel_found),
        .idx   (rel_idx)
    );

    // Two-flop synchronizer for the asynchronous column inputs; idles high (no key).
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // Debounce decision, pending-mask set/clear terms and event slot load enable.
    always_comb begin
        if (snapshot == prev_snap)
            deb_next = (deb_cnt == 4'hF) ? deb_cnt : deb_cnt + 4'd1;
        else
            deb_next = 4'd1;
        accept    = (state == ST_FRAME) && scan_en && (deb_next >= DEB_TH) && (snapshot != key_state);
        set_press = accept ? (snapshot & ~key_state) : '0;
        set_rel   = accept ? (~snapshot & key_state) : '0;
        slot_load = !key_valid || key_ready;
        clr_press = '0;
        clr_rel   = '0;
        if (slot_load) begin
            if (press_found)
                clr_press[press_idx] = 1'b1;
            else if (rel_found)
                clr_rel[rel_idx] = 1'b1;
        end
    end

    // Scan FSM: strobe each row, sample its columns, then close the frame.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            row       <= '1;
            row_idx   <= '0;
            div_cnt   <= '0;
            snapshot  <= '0;
            prev_snap <= '0;
            deb_cnt   <= '0;
        end else if (!scan_en) begin
            state     <= ST_IDLE;
            row       <= '1;
            row_idx   <= '0;
            div_cnt   <= '0;
            snapshot  <= '0;
            prev_snap <= '0;
            deb_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_DRIVE;
                    row     <= row_drive(3'd0);
                    row_idx <= '0;
                    div_cnt <= '0;
                end
                ST_DRIVE: begin
                    if (div_cnt == DIV_LAST)
                        state <= ST_SAMPLE;
                    else
                        div_cnt <= div_cnt + 16'd1;
                end
                ST_SAMPLE: begin
                    for (int unsigned r = 0; r < KPD_ROWS; r++) begin
                        if (row_idx == 3'(r))
                            snapshot[r*KPD_COLS +: KPD_COLS] <= ~col_sync;
                    end
                    div_cnt <= '0;
                    if (row_idx == 3'(KPD_ROWS - 1)) begin
                        state   <= ST_FRAME;
                        row     <= '1;
                        row_idx <= '0;
                    end else begin
                        state   <= ST_DRIVE;
                        row_idx <= row_idx + 3'd1;
                        row     <= row_drive(row_idx + 3'd1);
                    end
                end
                ST_FRAME: begin
                    deb_cnt <= deb_next;
                    if (snapshot != prev_snap)
                        prev_snap <= snapshot;
                    state <= ST_DRIVE;
                    row   <= row_drive(3'd0);
                end
                default: begin
                    state <= ST_IDLE;
                    row   <= '1;
                end
            endcase
        end
    end

    // Debounced map, pending masks (set beats clear) and the output event slot.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            key_state  <= '0;
            pend_press <= '0;
            pend_rel   <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            key_rel    <= 1'b0;
        end else begin
            if (accept)
                key_state <= snapshot;
            pend_press <= (pend_press & ~clr_press) | set_press;
            pend_rel   <= (pend_rel & ~clr_rel) | set_rel;
            if (slot_load) begin
                if (press_found) begin
                    key_valid <= 1'b1;
                    key_code  <= press_idx;
                    key_rel   <= 1'b0;
                end else if (rel_found) begin
                    key_valid <= 1'b1;
                    key_code  <= rel_idx;
                    key_rel   <= 1'b1;
                end else begin
                    key_valid <= 1'b0;
                end
            end
        end
    end

endmodule
